// File: rtl/ard00_ref_sequencer.sv
// Bandgap/reference power-up sequencer: enable, settle, trim, qualify refok, report ready/fault.
// Every output is registered, and refok adds two synchroniser stages. There is no backpressure; req is a level.
module ard00_ref_sequencer #(
  parameter int         BG_SETTLE   = 64,
  parameter int         TRIM_SETTLE = 16,
  parameter int         OK_FILT     = 8,
  parameter int         TIMEOUT     = 1024,
  parameter int         CNT_W       = 11,
  parameter logic [6:0] TRIM_RST    = 7'h40
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic [6:0] trim_otp,
  input  logic [6:0] trim_ovr,
  input  logic       trim_ovr_en,
  input  logic       tst_en,
  input  logic [1:0] tst_sel,
  input  logic       refok,
  output logic       en,
  output logic [6:0] trimBG,
  output logic       ten_bg,
  output logic       ten_ref,
  output logic       ready,
  output logic       fault,
  output logic       lost,
  output logic [2:0] state
);
  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_BG_EN = 3'd1;
  localparam logic [2:0] ST_TRIM  = 3'd2;
  localparam logic [2:0] ST_QUAL  = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BG_LAST   = CNT_W'(BG_SETTLE - 1);
  localparam logic [CNT_W-1:0] TRIM_LAST = CNT_W'(TRIM_SETTLE - 1);
  localparam logic [CNT_W-1:0] OK_LAST   = CNT_W'(OK_FILT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  logic             refok_meta;
  logic             refok_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] ok_inc;
  logic [CNT_W-1:0] low_inc;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] ok_nxt;
  logic [CNT_W-1:0] low_nxt;
  logic [2:0]       state_nxt;
  logic [6:0]       trim_nxt;
  logic             lost_nxt;
  logic             en_nxt;

  // Saturating increments: counters hold at all-ones instead of wrapping.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign ok_inc  = (ok_cnt == CNT_MAX) ? ok_cnt : ok_cnt + CNT_ONE;
  assign low_inc = (low_cnt == CNT_MAX) ? low_cnt : low_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refok_meta <= 1'b0;
      refok_s    <= 1'b0;
    end else begin
      refok_meta <= refok;
      refok_s    <= refok_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ok_nxt    = ok_cnt;
    low_nxt   = low_cnt;
    trim_nxt  = trimBG;
    lost_nxt  = 1'b0;
    if (!req) begin
      // Dropping req wins over every other transition.
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
      ok_nxt    = '0;
      low_nxt   = '0;
      trim_nxt  = TRIM_RST;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_BG_EN;
          cnt_nxt   = '0;
          trim_nxt  = TRIM_RST;
        end
        ST_BG_EN: begin
          if (cnt == BG_LAST) begin
            state_nxt = ST_TRIM;
            cnt_nxt   = '0;
            trim_nxt  = trim_ovr_en ? trim_ovr : trim_otp;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_TRIM: begin
          if (cnt == TRIM_LAST) begin
            state_nxt = ST_QUAL;
            cnt_nxt   = '0;
            ok_nxt    = '0;
            low_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_QUAL: begin
          cnt_nxt = cnt_inc;
          ok_nxt  = refok_s ? ok_inc : '0;
          // A filter hit on the timeout cycle still qualifies.
          if (refok_s && (ok_cnt == OK_LAST)) begin
            state_nxt = ST_READY;
            cnt_nxt   = '0;
            ok_nxt    = '0;
            low_nxt   = '0;
          end else if (cnt == TMO_LAST) begin
            state_nxt = ST_FAULT;
            cnt_nxt   = '0;
            ok_nxt    = '0;
            trim_nxt  = TRIM_RST;
          end
        end
        ST_READY: begin
          low_nxt = refok_s ? '0 : low_inc;
          if (trim_ovr_en) trim_nxt = trim_ovr;
          if (!refok_s && (low_cnt == OK_LAST)) begin
            state_nxt = ST_QUAL;
            lost_nxt  = 1'b1;
            cnt_nxt   = '0;
            ok_nxt    = '0;
            low_nxt   = '0;
          end
        end
        ST_FAULT: begin
          trim_nxt = TRIM_RST;
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          ok_nxt    = '0;
          low_nxt   = '0;
          trim_nxt  = TRIM_RST;
        end
      endcase
    end
  end

  always_comb begin
    en_nxt = (state_nxt == ST_BG_EN) || (state_nxt == ST_TRIM) ||
             (state_nxt == ST_QUAL)  || (state_nxt == ST_READY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_OFF;
      cnt     <= '0;
      ok_cnt  <= '0;
      low_cnt <= '0;
      en      <= 1'b0;
      trimBG  <= TRIM_RST;
      ten_bg  <= 1'b0;
      ten_ref <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      lost    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ok_cnt  <= ok_nxt;
      low_cnt <= low_nxt;
      en      <= en_nxt;
      trimBG  <= trim_nxt;
      // Test enables rise one cycle after en and fall on the same edge as en.
      ten_bg  <= tst_en & tst_sel[0] & en & en_nxt;
      ten_ref <= tst_en & tst_sel[1] & en & en_nxt;
      ready   <= (state_nxt == ST_READY);
      fault   <= (state_nxt == ST_FAULT);
      lost    <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_ard00_ref_sequencer.sv
// Bench for ard00_ref_sequencer: directed power-up scenarios followed by randomized refok/req traffic,
// all compared every cycle against a phase/age/history reference model.
module tb_ard00_ref_sequencer;
  localparam int BG  = 64;
  localparam int TS  = 16;
  localparam int OKF = 8;
  localparam int TMO = 1024;
  localparam int M_OFF = 0, M_BG = 1, M_TRIM = 2, M_QUAL = 3, M_READY = 4, M_FAULT = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req = 1'b0;
  logic [6:0] trim_otp = 7'h00;
  logic [6:0] trim_ovr = 7'h00;
  logic       trim_ovr_en = 1'b0;
  logic       tst_en = 1'b0;
  logic [1:0] tst_sel = 2'b00;
  logic       refok = 1'b1;
  logic       en;
  logic [6:0] trimBG;
  logic       ten_bg;
  logic       ten_ref;
  logic       ready;
  logic       fault;
  logic       lost;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, edges spent in it, and the synchronised refok samples seen there.
  int         m_mode;
  int         m_age;
  bit         m_hist[$];
  bit         m_s1, m_s2;
  logic [6:0] m_trim;
  bit         m_en, m_ready, m_fault, m_lost, m_tbg, m_tref;

  ard00_ref_sequencer dut (
    .clk(clk), .rstn(rstn), .req(req), .trim_otp(trim_otp), .trim_ovr(trim_ovr),
    .trim_ovr_en(trim_ovr_en), .tst_en(tst_en), .tst_sel(tst_sel), .refok(refok),
    .en(en), .trimBG(trimBG), .ten_bg(ten_bg), .ten_ref(ten_ref), .ready(ready),
    .fault(fault), .lost(lost), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_age = 0; m_hist.delete();
    m_s1 = 0; m_s2 = 0; m_trim = 7'h40;
    m_en = 0; m_ready = 0; m_fault = 0; m_lost = 0; m_tbg = 0; m_tref = 0;
  endtask

  function automatic int trailing(bit v);
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != v) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step();
    bit rs;
    bit prev_en;
    int nmode;
    rs = m_s2; m_s2 = m_s1; m_s1 = refok;
    prev_en = m_en;
    nmode = m_mode;
    m_lost = 0;
    m_age++;
    if (!req) nmode = M_OFF;
    else begin
      case (m_mode)
        M_OFF:  nmode = M_BG;
        M_BG:   if (m_age == BG) nmode = M_TRIM;
        M_TRIM: if (m_age == TS) nmode = M_QUAL;
        M_QUAL: begin
          m_hist.push_back(rs);
          if (trailing(1) >= OKF) nmode = M_READY;
          else if (m_age == TMO) nmode = M_FAULT;
        end
        M_READY: begin
          m_hist.push_back(rs);
          if (trailing(0) >= OKF) begin nmode = M_QUAL; m_lost = 1; end
        end
        default: nmode = m_mode;
      endcase
    end
    if (m_hist.size() > 64) void'(m_hist.pop_front());
    if (nmode == M_OFF || nmode == M_FAULT || nmode == M_BG) m_trim = 7'h40;
    else if (m_mode == M_BG && nmode == M_TRIM) m_trim = trim_ovr_en ? trim_ovr : trim_otp;
    else if (m_mode == M_READY && trim_ovr_en) m_trim = trim_ovr;
    if (nmode != m_mode) begin
      m_mode = nmode; m_age = 0; m_hist.delete();
    end
    m_en    = (m_mode >= M_BG) && (m_mode <= M_READY);
    m_ready = (m_mode == M_READY);
    m_fault = (m_mode == M_FAULT);
    m_tbg   = tst_en & tst_sel[0] & prev_en & m_en;
    m_tref  = tst_en & tst_sel[1] & prev_en & m_en;
  endtask

  task automatic check_all(string ph);
    chk({ph, ".state"}, 8'(state), 8'(m_mode));
    chk({ph, ".en"}, 8'(en), 8'(m_en));
    chk({ph, ".trim"}, 8'(trimBG), 8'(m_trim));
    chk({ph, ".ready"}, 8'(ready), 8'(m_ready));
    chk({ph, ".fault"}, 8'(fault), 8'(m_fault));
    chk({ph, ".lost"}, 8'(lost), 8'(m_lost));
    chk({ph, ".ten_bg"}, 8'(ten_bg), 8'(m_tbg));
    chk({ph, ".ten_ref"}, 8'(ten_ref), 8'(m_tref));
  endtask

  task automatic tick(string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  initial begin
    bit saw_lost;
    int run_left;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    model_reset();
    chk("rst.en", 8'(en), 8'h00);
    chk("rst.trim", 8'(trimBG), 8'h40);
    chk("rst.state", 8'(state), 8'h00);
    chk("rst.ready", 8'(ready), 8'h00);
    chk("rst.fault", 8'(fault), 8'h00);
    chk("rst.ten", 8'({ten_bg, ten_ref, lost}), 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    // Nominal power-up from OTP trim with refok steady high.
    trim_otp = 7'h2A;
    repeat (3) tick("idle");
    req = 1'b1;
    for (int i = 0; i <= 88; i++) begin
      tick("nom");
      if (i == 0)  chk("nom.en_e0", 8'(en), 8'h01);
      if (i == 63) chk("nom.trim_e63", 8'(trimBG), 8'h40);
      if (i == 64) chk("nom.trim_e64", 8'(trimBG), 8'h2A);
      if (i == 87) chk("nom.ready_e87", 8'(ready), 8'h00);
    end
    chk("nom.ready_e88", 8'(ready), 8'h01);
    chk("nom.state_e88", 8'(state), 8'h04);

    // Override trim, test mode, live trim, then release.
    req = 1'b0;
    tick("drop");
    trim_ovr_en = 1'b1; trim_ovr = 7'h15; tst_en = 1'b1; tst_sel = 2'b11;
    repeat (2) tick("off_tst");
    chk("tst.off_ten", 8'({ten_bg, ten_ref}), 8'h00);
    req = 1'b1;
    for (int i = 0; i <= 88; i++) begin
      tick("ovr");
      if (i == 0)  chk("tst.en_e0", 8'({en, ten_bg, ten_ref}), 8'h04);
      if (i == 1)  chk("tst.ten_e1", 8'({ten_bg, ten_ref}), 8'h03);
      if (i == 64) chk("ovr.trim_e64", 8'(trimBG), 8'h15);
    end
    chk("ovr.ready", 8'(ready), 8'h01);
    trim_ovr = 7'h16;
    tick("live");
    chk("live.trim", 8'(trimBG), 8'h16);
    chk("live.ready", 8'(ready), 8'h01);
    req = 1'b0;
    tick("tst_drop");
    chk("tst.drop", 8'({en, ten_bg, ten_ref}), 8'h00);

    // Qualification timeout with refok held low.
    refok = 1'b0; tst_en = 1'b0;
    repeat (3) tick("idle");
    req = 1'b1;
    for (int i = 0; i <= 80 + TMO; i++) begin
      tick("tmo");
      if (i == 80 + TMO - 1) chk("tmo.state_before", 8'(state), 8'h03);
    end
    chk("tmo.state", 8'(state), 8'h05);
    chk("tmo.flags", 8'({fault, en}), 8'h02);
    chk("tmo.trim", 8'(trimBG), 8'h40);
    req = 1'b0;
    tick("tmo_exit");
    chk("tmo.exit", 8'({state, fault}), 8'h00);

    // Glitch filtering in QUAL and READY.
    req = 1'b1;
    for (int i = 0; i <= 80; i++) tick("gl_up");
    chk("gl.qual", 8'(state), 8'h03);
    for (int p = 0; p < 10; p++) begin
      refok = 1'b1;
      repeat (7) tick("gl_q7");
      refok = 1'b0;
      tick("gl_q1");
    end
    chk("gl.no_ready", 8'({state, ready}), 8'h06);
    refok = 1'b1;
    repeat (12) tick("gl_qual");
    chk("gl.ready", 8'(ready), 8'h01);
    saw_lost = 0;
    refok = 1'b0;
    for (int i = 0; i < 7; i++) begin tick("gl_r7"); saw_lost |= lost; end
    refok = 1'b1;
    for (int i = 0; i < 4; i++) begin tick("gl_r7h"); saw_lost |= lost; end
    chk("gl.no_lost", 8'({saw_lost, ready}), 8'h01);
    refok = 1'b0;
    for (int i = 0; i < 12; i++) begin tick("gl_r8"); saw_lost |= lost; end
    chk("gl.lost", 8'(saw_lost), 8'h01);
    chk("gl.requal", 8'({state, ready}), 8'h06);

    // Abort in TRIM, then asynchronous reset in QUAL.
    req = 1'b0;
    tick("ab_off");
    req = 1'b1;
    for (int i = 0; i <= 70; i++) tick("ab_up");
    chk("ab.trim_state", 8'(state), 8'h02);
    req = 1'b0;
    tick("ab_drop");
    chk("ab.out", 8'({state, en, ready}), 8'h00);
    chk("ab.trim", 8'(trimBG), 8'h40);
    req = 1'b1;
    for (int i = 0; i <= 84; i++) tick("rs_up");
    chk("rs.qual", 8'(state), 8'h03);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("rs.out", 8'({state, en, ready}), 8'h00);
    chk("rs.trim", 8'(trimBG), 8'h40);
    req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic against the model.
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        refok = ~refok;
        run_left = $urandom_range(1, 14);
      end
      run_left--;
      req         = ($urandom_range(0, 499) != 0);
      trim_otp    = 7'($urandom);
      trim_ovr    = 7'($urandom);
      trim_ovr_en = ($urandom_range(0, 3) == 0);
      tst_en      = 1'($urandom_range(0, 1));
      tst_sel     = 2'($urandom);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
